// File: rtl/program_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words
// and writes them sequentially into instruction memory while holding the CPU.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err_partial,
    output logic                  err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  last_q, last_d;
    logic                  perr_q, perr_d;
    logic                  oerr_q, oerr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            last_q  <= 1'b0;
            perr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        last_d  = last_q;
        perr_d  = perr_q;
        oerr_d  = oerr_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    wptr_d  = '0;
                    cnt_d   = '0;
                    asm_d   = '0;
                    last_d  = 1'b0;
                    perr_d  = 1'b0;
                    oerr_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    asm_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (byte_last) begin
                        last_d = 1'b1;
                        if (idx_q != 2'd3) perr_d = 1'b1;
                    end
                    if (idx_q == 2'd3 || byte_last) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wptr_d = wptr_q + PTR_ONE;
                cnt_d  = cnt_q + CNT_ONE;
                idx_d  = '0;
                asm_d  = '0;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (wptr_q == '1) begin
                    // Memory full before the stream ended: stop, never wrap.
                    state_d = S_DONE;
                    oerr_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_ready   = (state_q == S_LOAD);
    assign mem_we       = (state_q == S_WRITE);
    assign cpu_hold     = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign mem_addr     = wptr_q;
    assign mem_wdata    = asm_q;
    assign word_count   = cnt_q;
    assign err_partial  = perr_q;
    assign err_overflow = oerr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: default-size instance plus a
// 4-word instance sharing the same stimulus for the overflow case.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic byte_last = 1'b0;

    logic        byte_ready, mem_we, cpu_hold, done, err_partial, err_overflow;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;

    logic        s_ready, s_we, s_hold, s_done, s_perr, s_oerr;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int total = 0;
    int bad = 0;
    int ready_bad = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [1:0]  sa[$];
    logic [31:0] sd[$];

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
        .word_count(word_count), .err_partial(err_partial),
        .err_overflow(err_overflow)
    );

    program_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) u_small (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(s_ready), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .cpu_hold(s_hold), .done(s_done),
        .word_count(s_count), .err_partial(s_perr),
        .err_overflow(s_oerr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (byte_ready !== 1'b0) ready_bad++;
        end
        if (s_we) begin
            sa.push_back(s_addr);
            sd.push_back(s_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); sa.delete(); sd.delete();
        ready_bad = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        while (byte_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {63'd0, byte_ready}, 64'd1);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_we",    {63'd0, mem_we}, 64'd0);
        chk("rst_hold",  {63'd0, cpu_hold}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_addr",  {56'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_count", {55'd0, word_count}, 64'd0);
        chk("rst_errs",  {62'd0, err_partial, err_overflow}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word, last on 4th byte
        clear_log();
        do_start();
        chk("t1_hold", {63'd0, cpu_hold}, 64'd1);
        chk("t1_ready", {63'd0, byte_ready}, 64'd1);
        send(8'h13, 1'b0);
        send(8'h05, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b1);
        chk("t1_we", {63'd0, mem_we}, 64'd1);
        chk("t1_we_hold", {63'd0, cpu_hold}, 64'd1);
        @(negedge clk);
        chk("t1_done", {63'd0, done}, 64'd1);
        chk("t1_hold_off", {63'd0, cpu_hold}, 64'd0);
        chk("t1_nwr", 64'(wa.size()), 64'd1);
        chk("t1_addr", {56'd0, wa[0]}, 64'd0);
        chk("t1_data", {32'd0, wd[0]}, 64'h00100513);
        chk("t1_count", {55'd0, word_count}, 64'd1);
        chk("t1_errs", {62'd0, err_partial, err_overflow}, 64'd0);

        // Three words, valid toggling, start pulse mid-load ignored
        clear_log();
        do_start();
        chk("t2_done_drop", {63'd0, done}, 64'd0);
        chk("t2_count_clr", {55'd0, word_count}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h10 + i), (i == 11));
            @(negedge clk);
            if (i == 5) do_start();
        end
        wait_done();
        chk("t2_nwr", 64'(wa.size()), 64'd3);
        chk("t2_addr0", {56'd0, wa[0]}, 64'd0);
        chk("t2_addr1", {56'd0, wa[1]}, 64'd1);
        chk("t2_addr2", {56'd0, wa[2]}, 64'd2);
        chk("t2_data0", {32'd0, wd[0]}, 64'h13121110);
        chk("t2_data1", {32'd0, wd[1]}, 64'h17161514);
        chk("t2_data2", {32'd0, wd[2]}, 64'h1B1A1918);
        chk("t2_ready_on_write", 64'(ready_bad), 64'd0);
        chk("t2_count", {55'd0, word_count}, 64'd3);

        // Partial final word
        clear_log();
        do_start();
        send(8'h93, 1'b0);
        send(8'h00, 1'b0);
        send(8'h50, 1'b0);
        send(8'h00, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        wait_done();
        chk("t3_nwr", 64'(wa.size()), 64'd2);
        chk("t3_data0", {32'd0, wd[0]}, 64'h00500093);
        chk("t3_addr1", {56'd0, wa[1]}, 64'd1);
        chk("t3_data1", {32'd0, wd[1]}, 64'h0000BBAA);
        chk("t3_perr", {63'd0, err_partial}, 64'd1);
        chk("t3_oerr", {63'd0, err_overflow}, 64'd0);
        chk("t3_count", {55'd0, word_count}, 64'd2);

        // Overflow on the 4-word instance; large instance takes all 5
        clear_log();
        do_start();
        chk("t4_perr_clr", {63'd0, err_partial}, 64'd0);
        chk("t4_sperr_clr", {63'd0, s_perr}, 64'd0);
        for (int i = 0; i < 20; i++) send(8'(8'h20 + i), (i == 19));
        wait_done();
        chk("t4_s_nwr", 64'(sa.size()), 64'd4);
        chk("t4_s_addr0", {62'd0, sa[0]}, 64'd0);
        chk("t4_s_addr3", {62'd0, sa[3]}, 64'd3);
        chk("t4_s_data3", {32'd0, sd[3]}, 64'h2F2E2D2C);
        chk("t4_s_done", {63'd0, s_done}, 64'd1);
        chk("t4_s_oerr", {63'd0, s_oerr}, 64'd1);
        chk("t4_s_ready", {63'd0, s_ready}, 64'd0);
        chk("t4_s_count", {61'd0, s_count}, 64'd4);
        chk("t4_nwr", 64'(wa.size()), 64'd5);
        chk("t4_data4", {32'd0, wd[4]}, 64'h33323130);
        chk("t4_oerr", {63'd0, err_overflow}, 64'd0);
        chk("t4_count", {55'd0, word_count}, 64'd5);

        // Reset mid-word, then reload from address 0
        clear_log();
        do_start();
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready", {63'd0, byte_ready}, 64'd0);
        chk("t5_hold", {63'd0, cpu_hold}, 64'd0);
        chk("t5_we", {63'd0, mem_we}, 64'd0);
        chk("t5_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("t5_addr", {56'd0, mem_addr}, 64'd0);
        chk("t5_count", {55'd0, word_count}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_nwr_rst", 64'(wa.size()), 64'd0);
        do_start();
        send(8'h6F, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        wait_done();
        chk("t5_nwr", 64'(wa.size()), 64'd1);
        chk("t5_addr0", {56'd0, wa[0]}, 64'd0);
        chk("t5_data0", {32'd0, wd[0]}, 64'h0000006F);

        // Single byte program from DONE
        clear_log();
        do_start();
        send(8'h7F, 1'b1);
        wait_done();
        chk("t6_nwr", 64'(wa.size()), 64'd1);
        chk("t6_data", {32'd0, wd[0]}, 64'h0000007F);
        chk("t6_perr", {63'd0, err_partial}, 64'd1);
        chk("t6_count", {55'd0, word_count}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
